// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: ALU op codes, operand-select encodings,
// forwarding-source enum and the ID/EX control bundle.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] A_SEL_RS1  = 2'd0;
  localparam logic [1:0] A_SEL_PC   = 2'd1;
  localparam logic [1:0] A_SEL_ZERO = 2'd2;

  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EXM = 2'd1,
    FWD_MWB = 2'd2
  } fwd_src_e;

  // All-zero value of this struct is the bubble (alu_control = ADD).
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] alu_control;
    logic [1:0] a_sel;
    logic       b_sel;
  } id_ex_ctrl_t;

  function automatic logic fwd_hit(input logic we, input logic [4:0] rd,
                                   input logic [4:0] rs);
    return we && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode inputs, hazard controls, forwarding sources and EX outputs.
// master = decode/hazard/pipeline side, slave = the stage itself.
interface id_ex_stage_if #(parameter int XLEN = 32);

  logic            stall;
  logic            flush;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic [4:0]      id_rd_addr;
  logic [3:0]      id_alu_control;
  logic [1:0]      id_a_sel;
  logic            id_b_sel;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_branch;

  logic            exm_reg_write;
  logic [4:0]      exm_rd;
  logic [XLEN-1:0] exm_result;
  logic            mwb_reg_write;
  logic [4:0]      mwb_rd;
  logic [XLEN-1:0] mwb_result;

  logic            ex_valid;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic [3:0]      ex_alu_control;
  logic [XLEN-1:0] ex_store_data;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_branch;
  logic            load_use;
  logic [31:0]     bubble_count;

  modport master (
    output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_control, id_a_sel,
           id_b_sel, id_reg_write, id_mem_read, id_mem_write, id_branch,
           exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
    input  ex_valid, ex_a, ex_b, ex_alu_control, ex_store_data, ex_pc, ex_imm,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
           load_use, bubble_count
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_control, id_a_sel,
           id_b_sel, id_reg_write, id_mem_read, id_mem_write, id_branch,
           exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
    output ex_valid, ex_a, ex_b, ex_alu_control, ex_store_data, ex_pc, ex_imm,
           ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
           load_use, bubble_count
  );

endinterface

// File: rtl/id_ex_stage_fwd_unit.sv
// Per-operand forwarding select; purely combinational.
// EX/MEM beats MEM/WB beats register-file data; x0 is never forwarded.
module fwd_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      i_rs,
  input  logic [XLEN-1:0] i_reg_data,
  input  logic            i_exm_reg_write,
  input  logic [4:0]      i_exm_rd,
  input  logic [XLEN-1:0] i_exm_result,
  input  logic            i_mwb_reg_write,
  input  logic [4:0]      i_mwb_rd,
  input  logic [XLEN-1:0] i_mwb_result,
  output logic [XLEN-1:0] o_data
);

  fwd_src_e w_src;

  always_comb begin
    w_src = FWD_REG;
    if (fwd_hit(i_exm_reg_write, i_exm_rd, i_rs)) begin
      w_src = FWD_EXM;
    end else if (fwd_hit(i_mwb_reg_write, i_mwb_rd, i_rs)) begin
      w_src = FWD_MWB;
    end
  end

  always_comb begin
    o_data = i_reg_data;
    case (w_src)
      FWD_EXM: o_data = i_exm_result;
      FWD_MWB: o_data = i_mwb_result;
      default: o_data = i_reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand muxing,
// load-use detection, stall/flush handling and a bubble counter.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);

  id_ex_ctrl_t     r_ctrl;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [31:0]     r_bubble_count;

  id_ex_ctrl_t     w_id_ctrl;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic            w_load_use;
  logic            w_load_bubble;
  logic            w_ex_mem_read;

  always_comb begin
    w_id_ctrl             = '0;
    w_id_ctrl.valid       = bus.id_valid;
    w_id_ctrl.reg_write   = bus.id_reg_write;
    w_id_ctrl.mem_read    = bus.id_mem_read;
    w_id_ctrl.mem_write   = bus.id_mem_write;
    w_id_ctrl.branch      = bus.id_branch;
    w_id_ctrl.rd          = bus.id_rd_addr;
    w_id_ctrl.rs1         = bus.id_rs1_addr;
    w_id_ctrl.rs2         = bus.id_rs2_addr;
    w_id_ctrl.alu_control = bus.id_alu_control;
    w_id_ctrl.a_sel       = bus.id_a_sel;
    w_id_ctrl.b_sel       = bus.id_b_sel;
  end

  assign w_ex_mem_read = r_ctrl.valid & r_ctrl.mem_read;

  assign w_load_use = w_ex_mem_read && (r_ctrl.rd != 5'd0) && bus.id_valid &&
                      ((bus.id_rs1_addr == r_ctrl.rd) || (bus.id_rs2_addr == r_ctrl.rd));

  // Flush overrides stall; a load-use bubble only goes in when the stage can move.
  assign w_load_bubble = bus.flush | (~bus.stall & w_load_use);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl         <= '0;
      r_pc           <= '0;
      r_rs1_data     <= '0;
      r_rs2_data     <= '0;
      r_imm          <= '0;
      r_bubble_count <= '0;
    end else if (w_load_bubble) begin
      r_ctrl         <= '0;
      r_pc           <= '0;
      r_rs1_data     <= '0;
      r_rs2_data     <= '0;
      r_imm          <= '0;
      r_bubble_count <= r_bubble_count + 32'd1;
    end else if (!bus.stall) begin
      r_ctrl         <= w_id_ctrl;
      r_pc           <= bus.id_pc;
      r_rs1_data     <= bus.id_rs1_data;
      r_rs2_data     <= bus.id_rs2_data;
      r_imm          <= bus.id_imm;
    end
  end

  fwd_unit #(.XLEN(XLEN)) u_fwd_rs1 (
    .i_rs            (r_ctrl.rs1),
    .i_reg_data      (r_rs1_data),
    .i_exm_reg_write (bus.exm_reg_write),
    .i_exm_rd        (bus.exm_rd),
    .i_exm_result    (bus.exm_result),
    .i_mwb_reg_write (bus.mwb_reg_write),
    .i_mwb_rd        (bus.mwb_rd),
    .i_mwb_result    (bus.mwb_result),
    .o_data          (w_fwd_rs1)
  );

  fwd_unit #(.XLEN(XLEN)) u_fwd_rs2 (
    .i_rs            (r_ctrl.rs2),
    .i_reg_data      (r_rs2_data),
    .i_exm_reg_write (bus.exm_reg_write),
    .i_exm_rd        (bus.exm_rd),
    .i_exm_result    (bus.exm_result),
    .i_mwb_reg_write (bus.mwb_reg_write),
    .i_mwb_rd        (bus.mwb_rd),
    .i_mwb_result    (bus.mwb_result),
    .o_data          (w_fwd_rs2)
  );

  // Encoding 3 of a_sel is reserved and behaves as zero.
  always_comb begin
    bus.ex_a = '0;
    case (r_ctrl.a_sel)
      A_SEL_RS1: bus.ex_a = w_fwd_rs1;
      A_SEL_PC:  bus.ex_a = r_pc;
      default:   bus.ex_a = '0;
    endcase
  end

  assign bus.ex_b           = (r_ctrl.b_sel == B_SEL_IMM) ? r_imm : w_fwd_rs2;
  assign bus.ex_store_data  = w_fwd_rs2;
  assign bus.ex_valid       = r_ctrl.valid;
  assign bus.ex_alu_control = r_ctrl.alu_control;
  assign bus.ex_pc          = r_pc;
  assign bus.ex_imm         = r_imm;
  assign bus.ex_rd          = r_ctrl.rd;
  assign bus.ex_reg_write   = r_ctrl.valid & r_ctrl.reg_write;
  assign bus.ex_mem_read    = w_ex_mem_read;
  assign bus.ex_mem_write   = r_ctrl.valid & r_ctrl.mem_write;
  assign bus.ex_branch      = r_ctrl.valid & r_ctrl.branch;
  assign bus.load_use       = w_load_use;
  assign bus.bubble_count   = r_bubble_count;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage for the RISC-V core. It registers decoded instruction fields and control at the ID/EX boundary, and applies forwarding from the EX/MEM and MEM/WB stages. It selects the ALU operands and drives the ALU's `a`, `b` and `alu_control` directly. It also detects load-use hazards and supports stall (hold) and flush (bubble) from the hazard/branch logic.

## Interface
- `XLEN`, default 32: datapath width.
- `clk  in  1`: core clock; all state on rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `stall  in  1`: hold the stage register; downstream not ready.
- `flush  in  1`: replace the next stage contents with a bubble (branch taken / trap).
- `id_valid  in  1`: decode slot holds a real instruction.
- `id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each`: decoded values.
- `id_rs1_addr, id_rs2_addr, id_rd_addr  in  5 each`: register indices.
- `id_alu_control  in  4`: ALU op code, taken from the shared package.
- `id_a_sel  in  2`: operand A source. `0`=rs1, `1`=pc, `2`=zero; `3` is reserved and treated as zero.
- `id_b_sel  in  1`: operand B source. `0`=rs2, `1`=imm.
- `id_reg_write, id_mem_read, id_mem_write, id_branch  in  1 each`: control bits.
- `exm_reg_write  in  1`, `exm_rd  in  5`, `exm_result  in  XLEN`: EX/MEM forwarding source.
- `mwb_reg_write  in  1`, `mwb_rd  in  5`, `mwb_result  in  XLEN`: MEM/WB forwarding source.
- `ex_valid  out  1`: EX slot holds a real instruction.
- `ex_a, ex_b  out  XLEN`: ALU operands.
- `ex_alu_control  out  4`: ALU op.
- `ex_store_data  out  XLEN`: forwarded rs2, used for stores.
- `ex_pc, ex_imm  out  XLEN`: for branch target calculation.
- `ex_rd  out  5`: destination register index.
- `ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1 each`: control bits, gated by `ex_valid`.
- `load_use  out  1`: request to freeze IF/ID for one cycle.
- `bubble_count  out  32`: count of bubbles inserted since reset.

## Operation
- Stage register update priority each cycle:
  - `flush` loads a bubble.
  - else `stall` holds the current contents.
  - else `load_use` loads a bubble.
  - else the stage loads the `id_*` inputs.
- Bubble contents: `valid`=0, all control bits 0, `rd`=0, `alu_control`=ADD (0000). The data fields are don't-care but are cleared to 0.
- Forwarding is combinational on the registered rs1 and rs2 indices, with this priority:
  - EX/MEM, when `exm_reg_write` and `exm_rd`≠0 and `exm_rd`==rs.
  - else MEM/WB, under the same conditions using the `mwb_*` signals.
  - else the registered register-file data.
- Register x0 is never forwarded.
- Operands: `ex_a` = mux(`a_sel`) of fwd_rs1 / pc / 0. `ex_b` = `b_sel` ? imm : fwd_rs2. `ex_store_data` = fwd_rs2 always.
- `load_use` = `ex_valid` & `ex_mem_read` & `ex_rd`≠0 & `id_valid` & (`id_rs1_addr`==`ex_rd` | `id_rs2_addr`==`ex_rd`). It is purely combinational.
- `bubble_count` increments by 1 on every edge where a bubble is loaded, whether by flush or by load_use. A hold caused by stall does not count. The counter wraps from 2^32−1 to 0.

## Timing
- Reset (asynchronous, takes effect immediately): every registered field is 0. This gives `ex_valid`=0, all control outputs 0, `ex_alu_control`=0000, `ex_a`=`ex_b`=0 (provided the forwarding sources are inactive), and `bubble_count`=0.
- Latency: `id_*` sampled at edge N appear on the `ex_*` outputs after edge N; the ALU consumes them in cycle N+1.
- Forwarding has zero latency: a change on `exm_*`/`mwb_*` within a cycle is reflected on `ex_a`/`ex_b` in the same cycle. This holds during stall too, so a held instruction picks up newly retired results.
- Simultaneous `flush` and `stall`: the flush wins; the bubble loads and the count increments.
- Simultaneous `stall` and `load_use`: the stage holds and no bubble is counted. `load_use` stays asserted until the stall releases.
- A load-use bubble lasts exactly one cycle. On the next cycle `ex_mem_read`=0, so `load_use` deasserts and the dependent instruction proceeds, forwarded from MEM/WB.
- Reset asserted mid-stall or mid-flush overrides everything.

## Structure
- The shared package `riscv_pkg` holds:
  - ALU op localparams: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
  - `a_sel` encodings (RS1/PC/ZERO).
  - `b_sel` encodings (RS2/IMM).
  - The forwarding-source enum (REG/EXM/MWB).
- Sub-module `fwd_unit`: a purely combinational per-operand forwarding select, instantiated twice (rs1 and rs2).

## Test plan
- Basic load: `id` ADD with rs1=5 (data 10), rs2=6 (data 20), b_sel=0, no hazards. The next cycle must show `ex_a`=10, `ex_b`=20, `ex_alu_control`=0000, `ex_valid`=1.
- Forwarding priority: EX rs1=3 with `exm_rd`=3 (result 0xAA) and `mwb_rd`=3 (result 0xBB), both writes high → `ex_a`=0xAA. With `exm_rd`=0 instead → `ex_a`=0xBB.
- x0 guard: rs1=0 with `exm_rd`=0 and `exm_reg_write`=1 (result 0xFF) → `ex_a` = registered rs1 data (0).
- Load-use: EX holds lw with rd=7, and ID holds an instruction with rs2=7.
  - `load_use`=1 in that cycle.
  - The next cycle `ex_valid`=0 and `bubble_count`=1.
  - The following cycle the dependent instruction loads.
- Control priority: `stall`=1 for 3 cycles holds `ex_*` unchanged. `flush`+`stall` together → `ex_valid`=0, `ex_reg_write`=0, `bubble_count`+1.
- Reset: assert `rst` asynchronously mid-stream → all outputs 0 immediately, without waiting for a `clk` edge.
